// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control path: FSM states and button indices.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_e;

  localparam int NUM_BTN   = 3;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_RESET = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// rising-edge detector that emits one pulse per press regardless of hold time.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, IDLE/RUNNING/PAUSED FSM and the
// clock divider that produces the one-cycle count_en tick for the seconds counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               stop_btn,
  input  logic               reset_btn,
  output logic               count_en,
  output logic               count_clr,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [NUM_BTN-1:0] btn_vec;
  logic [NUM_BTN-1:0] pulse;

  assign btn_vec[BTN_START] = start_btn;
  assign btn_vec[BTN_STOP]  = stop_btn;
  assign btn_vec[BTN_RESET] = reset_btn;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_sync_edge u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_vec[gi]),
        .pulse_o (pulse[gi])
      );
    end
  endgenerate

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             count_clr_q, count_clr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      count_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      count_clr_q <= count_clr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    div_cnt_d   = div_cnt_q;

    // Strict priority: a stop pulse masks a coincident start pulse.
    if (pulse[BTN_RESET]) begin
      state_d     = ST_IDLE;
      count_clr_d = 1'b1;
    end else if (pulse[BTN_STOP]) begin
      if (state_q == ST_RUNNING) state_d = ST_PAUSED;
    end else if (pulse[BTN_START] && (state_q != ST_RUNNING)) begin
      state_d = ST_RUNNING;
    end

    // PAUSED holds the divider so the partial tick interval survives a pause.
    if (state_d == ST_IDLE) begin
      div_cnt_d = '0;
    end else if (state_q == ST_RUNNING) begin
      div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  assign running   = (state_q == ST_RUNNING);
  assign count_en  = running && (div_cnt_q == DIV_MAX);
  assign count_clr = count_clr_q;
  assign state     = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timebase stage directly upstream of the seconds counter in the stopwatch datapath. It synchronizes and edge-detects the start, stop and reset buttons and runs the IDLE/RUNNING/PAUSED state machine. It also divides the system clock into a one-cycle `count_en` tick while running, and issues a one-cycle `count_clr` pulse on user reset. `count_en` and `count_clr` drive the seconds counter's `enable` and `clear` inputs directly.

## Interface
- `CLK_DIV`, default 100000000: clock cycles per count tick; legal range ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_btn`  in  1  asynchronous level, active-high.
- `stop_btn`  in  1  asynchronous level, active-high.
- `reset_btn`  in  1  asynchronous level, active-high.
- `count_en`  out  1  one-cycle tick to the seconds counter `enable`.
- `count_clr`  out  1  one-cycle clear to the seconds counter `clear`.
- `running`  out  1  high when in RUNNING.
- `state`  out  2  current state: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.

## Operation
- Each button has its own input path:
  - two-flop synchronizer, then a previous-value flop;
  - pulse = sync2 & ~prev, giving one pulse per rising edge regardless of hold time.
- Pulse priority: reset > stop > start.
- State transitions:
  - any state + reset pulse → IDLE, and `count_clr` is set.
  - RUNNING + stop → PAUSED.
  - IDLE or PAUSED + start → RUNNING.
  - All other combinations hold state. This includes start in RUNNING, stop in IDLE and stop in PAUSED.
- Divider `div_cnt`:
  - width `$clog2(CLK_DIV)`, minimum 1 bit.
  - In RUNNING: advances every cycle, wrapping from CLK_DIV-1 to 0.
  - In PAUSED: holds, so the partial tick interval is preserved.
  - Forced to 0 whenever the next state is IDLE.
- `count_en` = (state==RUNNING) && (div_cnt==CLK_DIV-1). It is combinational from registers.
- With CLK_DIV=1, `count_en` is high on every RUNNING cycle.
- `count_clr` is a register, high for exactly one cycle after each reset pulse. This includes a reset pulse received while already in IDLE.
- `running` = (state==RUNNING).

## Timing
- On `rst` (synchronous, active-high), the following are zeroed:
  - `state`, `div_cnt`, `count_clr`;
  - all synchronizer and prev flops.
- Resulting output values during reset: `state`=IDLE, `count_en`=0, `count_clr`=0, `running`=0.
- `rst` mid-operation overrides everything at the next edge.
- Button latency: a button rising before edge k produces a pulse in the cycle after edge k+1. The state and `count_clr` update at edge k+2.
- Tick spacing after entering RUNNING from IDLE:
  - the first `count_en` falls in the CLK_DIV-th RUNNING cycle;
  - subsequent ticks are exactly CLK_DIV cycles apart.
- Stop pulse in a cycle where `count_en`=1:
  - the tick is still issued;
  - `div_cnt` wraps to 0 and holds in PAUSED.
- `count_en` is never high in IDLE or PAUSED.
- `count_clr` and `count_en` are never high in the same cycle.

## Structure
- Shared package/header `stopwatch_pkg` holds:
  - the state encoding constants `ST_IDLE`, `ST_RUNNING`, `ST_PAUSED`;
  - the `STATE_W`=2 constant.
- Sub-module `btn_sync_edge`: two-flop synchronizer plus rising-edge pulse, instantiated three times.
- Divider and FSM live in the top module.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset:** hold `rst` for 2 cycles with random buttons → `state`=00; `count_en`, `count_clr` and `running` all 0 throughout.
- **Start and tick rate:** `start_btn` high for 1 cycle → `state`=01 at the 3rd edge; `count_en` high in RUNNING cycles 4, 8 and 12. With the seconds counter attached, it reads 3 after 12 RUNNING cycles.
- **Pause and resume:** stop takes effect with `div_cnt`=2 → PAUSED, no `count_en` for 50 cycles; start again → `count_en` in the 2nd RUNNING cycle after resume.
- **Reset while running:** `reset_btn` in RUNNING → IDLE with `count_clr`=1 for exactly one cycle; `div_cnt`=0; the next start gives its first tick at RUNNING cycle 4.
- **Simultaneous buttons:**
  - start+stop+reset together in PAUSED → IDLE with a `count_clr` pulse;
  - start+stop together in RUNNING → PAUSED.
- **Long press and async reset:**
  - `start_btn` held high for 20 cycles → exactly one transition, with no re-trigger;
  - `rst` asserted mid-RUNNING → IDLE at the next edge with no `count_en`.
